vpu_stream: RTL and testbench
=============================

# vpu_stream

Multi-lane, stream-handshaked vector post-processing unit that sits between the systolic array accumulator outputs and the unified buffer write path. Each beat carries LANES signed accumulator values. Every lane goes through the same steps in order: bias add, configurable activation, scale-multiply, rounding right shift, and saturation to OUT_W-bit signed. Data flows through a 3-stage stallable pipeline with valid/ready flow control. A sticky saturation counter supports quantization debugging.

## Interface
- LANES, 4, number of parallel lanes (columns)
- IN_W, 32, signed input/bias width
- OUT_W, 8, signed output width (OUT_W < IN_W)
- CNT_W, 16, saturation counter width
- clk  in  1  clock, all logic on rising edge
- reset  in  1  synchronous, active-high; clock clk
- in_valid  in  1  input beat valid
- in_ready  out  1  unit can accept a beat this cycle
- in_data  in  LANES*IN_W  lane i at [i*IN_W +: IN_W], signed
- in_bias  in  LANES*IN_W  per-lane signed bias, same packing
- act_type  in  3  000 passthrough, 001 ReLU, 010 ReLU-clip, 011 leaky ReLU, others are treated as passthrough
- clip_val  in  IN_W  upper clip for ReLU-clip, treated as non-negative signed
- scale  in  16  unsigned multiplier
- shift  in  5  right-shift amount 0..31
- out_valid  out  1  output beat valid
- out_ready  in  1  downstream accepts
- out_data  out  LANES*OUT_W  lane i at [i*OUT_W +: OUT_W], signed
- sat_count  out  CNT_W  number of lane results saturated since reset/clear
- sat_clear  in  1  zero sat_count

## Operation
- Configuration (act_type, clip_val, scale, shift, in_bias) is captured with the beat when it is accepted (in_valid && in_ready) and travels down the pipeline with it. Configuration may change on every beat, and each beat uses its own values.
- S1, bias and activation:
  - s = in_data + in_bias, computed at IN_W+1 bits, then saturated to IN_W signed.
  - ReLU: s<0 gives 0.
  - ReLU-clip: s<0 gives 0; s>clip_val gives clip_val.
  - Leaky ReLU: s<0 gives s>>>3 (floor); otherwise s.
  - Passthrough: s.
- S2, scale: p = a * $signed({1'b0,scale}), full IN_W+17 bits, no truncation.
- S3, round, shift and saturate:
  - If shift>0, r = (p + (1<<(shift-1))) >>> shift (round half up toward +inf); if shift=0, r = p.
  - Saturate r to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Each lane that clips is one saturation event.
- sat_count adds the number of saturated lanes in the beat leaving S3 (0..LANES) when that beat is accepted downstream. The counter sticks at all-ones and does not wrap.
- sat_clear zeroes sat_count. If sat_clear coincides with an accepted output beat, the result is 0; the clear wins and the beat's events are dropped.

## Timing
- Latency: 3 cycles from an accepted input beat to out_valid for that beat when there is no stall. Throughput is one beat per cycle.
- Stall rule: stall = out_valid && !out_ready.
  - in_ready = !stall, a combinational function of out_valid and out_ready only.
  - When stalled, all stage registers and valid bits hold.
  - Bubbles (invalid stages) are not compressed during a stall.
- out_data and out_valid are registered and held stable while stalled. out_data does not change until out_ready is seen high with out_valid.
- in_valid while in_ready=0 is ignored. The upstream must hold its beat.
- Reset values: all stage valid bits 0, out_valid=0, out_data=0, sat_count=0, in_ready=1 from the first cycle after reset.
- Reset mid-stream discards every in-flight beat with no output produced. A beat presented in the same cycle as reset is not accepted.
- Beat ordering is preserved, with no duplication and no loss under arbitrary out_ready patterns.

## Test plan
- Passthrough, scale=1, shift=0, IN_W=32, OUT_W=8, lanes {5,-3,127,-128}, bias 0 -> out {5,-3,127,-128} exactly 3 cycles after acceptance; sat_count=0.
- Activations, lanes {-16,-1,10,100}, bias 0, scale=1, shift=0, clip_val=6:
  - ReLU -> {0,0,10,100}
  - ReLU-clip -> {0,0,6,6}
  - Leaky ReLU -> {-2,-1,10,100}
- Requantization, lanes {1000,-1000,6,-6}, bias {24,0,0,0}, scale=3, shift=4, passthrough -> {127,-128,1,-1}; this is 1024*3/16=192, saturated to 127, and -3000/16 = -187.5, saturated to -128; sat_count increments by 2.
- Rounding boundary, scale=1, shift=1, lanes {3,-3,1,-1} -> {2,-1,1,0} (round half up).
- Backpressure: 8 back-to-back beats with distinct values; out_ready toggles with the pattern 1,0,0,1,0,1,1,0,... -> all 8 beats emerge in order, each unchanged while stalled; in_ready low exactly in cycles where out_valid && !out_ready.
- Reset and counters:
  - Assert reset with 3 beats in flight -> next cycle out_valid=0 and sat_count=0, and no stale beat appears afterwards.
  - Drive sat_count to all-ones -> it sticks there.
  - sat_clear coincident with a saturating output beat -> sat_count=0.

Source files
------------

// File: rtl/vpu_stream.sv
// Vector post-processing unit: per-lane bias add, activation, scale, rounding shift
// and saturation over a 3-stage stallable valid/ready pipeline with a saturation counter.
module vpu_stream #(
   parameter int LANES = 4,
   parameter int IN_W  = 32,
   parameter int OUT_W = 8,
   parameter int CNT_W = 16
) (
   input  logic                   clk,
   input  logic                   reset,
   input  logic                   in_valid,
   output logic                   in_ready,
   input  logic [LANES*IN_W-1:0]  in_data,
   input  logic [LANES*IN_W-1:0]  in_bias,
   input  logic [2:0]             act_type,
   input  logic [IN_W-1:0]        clip_val,
   input  logic [15:0]            scale,
   input  logic [4:0]             shift,
   output logic                   out_valid,
   input  logic                   out_ready,
   output logic [LANES*OUT_W-1:0] out_data,
   output logic [CNT_W-1:0]       sat_count,
   input  logic                   sat_clear
);

   localparam int P_W = IN_W + 17;
   localparam int R_W = IN_W + 18;
   localparam logic signed [R_W-1:0] C_OMAX = R_W'((2 ** (OUT_W - 1)) - 1);
   localparam logic signed [R_W-1:0] C_OMIN = ~C_OMAX;

   logic                   w_stall;
   logic                   w_adv;
   logic [LANES*IN_W-1:0]  w_a_all;
   logic [LANES*P_W-1:0]   w_p_all;
   logic [LANES*OUT_W-1:0] w_o_all;
   logic [LANES-1:0]       w_sat_all;
   logic [CNT_W:0]         w_nsat;
   logic [CNT_W:0]         w_cnt_sum;
   logic [CNT_W-1:0]       w_cnt_next;

   logic                   r_v1;
   logic                   r_v2;
   logic                   r_out_valid;
   logic [LANES*IN_W-1:0]  r_a_all;
   logic [LANES*P_W-1:0]   r_p_all;
   logic [LANES*OUT_W-1:0] r_out_data;
   logic [LANES-1:0]       r_sat;
   logic [15:0]            r_scale1;
   logic [4:0]             r_shift1;
   logic [4:0]             r_shift2;
   logic [CNT_W-1:0]       r_sat_count;

   assign w_stall   = r_out_valid && !out_ready;
   assign w_adv     = !w_stall;
   assign in_ready  = w_adv;
   assign out_valid = r_out_valid;
   assign out_data  = r_out_data;
   assign sat_count = r_sat_count;

   generate
      for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
         logic signed [IN_W-1:0] w_d;
         logic signed [IN_W-1:0] w_b;
         logic signed [IN_W:0]   w_sum;
         logic signed [IN_W-1:0] w_s;
         logic signed [IN_W-1:0] w_act;
         logic [IN_W-1:0]        w_a2;
         logic [P_W-1:0]         w_ax;
         logic [P_W-1:0]         w_sx;
         logic [P_W-1:0]         w_p3;
         logic [R_W-1:0]         w_rnd;
         logic signed [R_W-1:0]  w_pr;
         logic signed [R_W-1:0]  w_r;
         logic [OUT_W-1:0]       w_o;
         logic                   w_sat;

         assign w_d   = in_data[gi*IN_W +: IN_W];
         assign w_b   = in_bias[gi*IN_W +: IN_W];
         assign w_sum = {w_d[IN_W-1], w_d} + {w_b[IN_W-1], w_b};

         // The two top bits of the widened sum disagree only on overflow.
         always_comb begin
            w_s = w_sum[IN_W-1:0];
            if (w_sum[IN_W] != w_sum[IN_W-1]) begin
               w_s = w_sum[IN_W] ? {1'b1, {(IN_W-1){1'b0}}} : {1'b0, {(IN_W-1){1'b1}}};
            end
         end

         always_comb begin
            w_act = w_s;
            case (act_type)
               3'b001: if (w_s[IN_W-1]) w_act = '0;
               3'b010: begin
                  if (w_s[IN_W-1])
                     w_act = '0;
                  else if (w_s > $signed(clip_val))
                     w_act = clip_val;
               end
               3'b011: if (w_s[IN_W-1]) w_act = w_s >>> 3;
               default: w_act = w_s;
            endcase
         end

         assign w_a_all[gi*IN_W +: IN_W] = w_act;

         // Full-width product: operands widened so the low P_W bits are exact.
         assign w_a2 = r_a_all[gi*IN_W +: IN_W];
         assign w_ax = {{17{w_a2[IN_W-1]}}, w_a2};
         assign w_sx = {{IN_W{1'b0}}, 1'b0, r_scale1};
         assign w_p_all[gi*P_W +: P_W] = w_ax * w_sx;

         // Half-LSB rounding constant; collapses to zero when shift is zero.
         assign w_p3  = r_p_all[gi*P_W +: P_W];
         assign w_rnd = (R_W'(1) << r_shift2) >> 1;
         assign w_pr  = $signed({w_p3[P_W-1], w_p3}) + $signed(w_rnd);
         assign w_r   = w_pr >>> r_shift2;

         always_comb begin
            w_o   = w_r[OUT_W-1:0];
            w_sat = 1'b0;
            if (w_r > C_OMAX) begin
               w_o   = C_OMAX[OUT_W-1:0];
               w_sat = 1'b1;
            end else if (w_r < C_OMIN) begin
               w_o   = C_OMIN[OUT_W-1:0];
               w_sat = 1'b1;
            end
         end

         assign w_o_all[gi*OUT_W +: OUT_W] = w_o;
         assign w_sat_all[gi]               = w_sat;
      end
   endgenerate

   always_comb begin
      w_nsat = '0;
      for (int i = 0; i < LANES; i++) begin
         w_nsat = w_nsat + (CNT_W+1)'(r_sat[i]);
      end
   end

   assign w_cnt_sum  = {1'b0, r_sat_count} + w_nsat;
   assign w_cnt_next = w_cnt_sum[CNT_W] ? '1 : w_cnt_sum[CNT_W-1:0];

   always_ff @(posedge clk) begin
      if (reset) begin
         r_v1        <= 1'b0;
         r_v2        <= 1'b0;
         r_out_valid <= 1'b0;
         r_a_all     <= '0;
         r_p_all     <= '0;
         r_out_data  <= '0;
         r_sat       <= '0;
         r_scale1    <= '0;
         r_shift1    <= '0;
         r_shift2    <= '0;
         r_sat_count <= '0;
      end else begin
         if (w_adv) begin
            r_v1        <= in_valid;
            r_a_all     <= w_a_all;
            r_scale1    <= scale;
            r_shift1    <= shift;
            r_v2        <= r_v1;
            r_p_all     <= w_p_all;
            r_shift2    <= r_shift1;
            r_out_valid <= r_v2;
            if (r_v2) begin
               r_out_data <= w_o_all;
               r_sat      <= w_sat_all;
            end
         end
         if (sat_clear)
            r_sat_count <= '0;
         else if (r_out_valid && out_ready)
            r_sat_count <= w_cnt_next;
      end
   end

endmodule

// File: tb/tb_vpu_stream.sv
// Directed self-checking bench for vpu_stream: activations, requantization, rounding,
// backpressure ordering, reset flush and saturation counter behaviour.
module tb_vpu_stream;

   logic         clk;
   logic         reset;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] in_data;
   logic [127:0] in_bias;
   logic [2:0]   act_type;
   logic [31:0]  clip_val;
   logic [15:0]  scale;
   logic [4:0]   shift;
   logic         out_valid;
   logic         out_ready;
   logic [31:0]  out_data;
   logic [15:0]  sat_count;
   logic         sat_clear;

   int n_total = 0;
   int n_bad   = 0;

   vpu_stream #(.LANES(4), .IN_W(32), .OUT_W(8), .CNT_W(16)) dut (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_bias   (in_bias),
      .act_type  (act_type),
      .clip_val  (clip_val),
      .scale     (scale),
      .shift     (shift),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .sat_count (sat_count),
      .sat_clear (sat_clear)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_total++;
      if (obs !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, obs, exp);
      end else begin
         $display("ok   %s: %0h", tag, obs);
      end
   endtask

   function automatic logic [127:0] pk_in(input int a, input int b, input int c, input int d);
      return {d, c, b, a};
   endfunction

   function automatic logic [31:0] pk_out(input int a, input int b, input int c, input int d);
      return {d[7:0], c[7:0], b[7:0], a[7:0]};
   endfunction

   // One isolated beat with out_ready high; config is scrambled after acceptance.
   task automatic run_one(input string tag, input logic [127:0] d, input logic [127:0] b,
                          input logic [2:0] act, input logic [31:0] clip, input logic [15:0] sc,
                          input logic [4:0] sh, input logic [31:0] eout, input logic [15:0] esat);
      int lat;
      @(negedge clk);
      in_data  = d;
      in_bias  = b;
      act_type = act;
      clip_val = clip;
      scale    = sc;
      shift    = sh;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = '0;
      in_bias  = '0;
      act_type = 3'b111;
      clip_val = '0;
      scale    = 16'd0;
      shift    = 5'd0;
      lat = 1;
      while (!out_valid && lat < 10) begin
         @(negedge clk);
         lat++;
      end
      chk({tag, "_lat"}, lat, 3);
      chk({tag, "_data"}, out_data, eout);
      @(negedge clk);
      chk({tag, "_sat"}, sat_count, esat);
   endtask

   logic [7:0]  bp_pat;
   logic [31:0] bp_exp [8];
   logic [31:0] held_d;
   logic        held_v;
   int          tx;
   int          rx;
   int          wcnt;

   initial begin
      reset     = 1'b1;
      in_valid  = 1'b0;
      in_data   = '0;
      in_bias   = '0;
      act_type  = 3'b000;
      clip_val  = '0;
      scale     = 16'd1;
      shift     = 5'd0;
      out_ready = 1'b1;
      sat_clear = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      chk("rst_out_valid", out_valid, 0);
      chk("rst_out_data", out_data, 0);
      chk("rst_sat_count", sat_count, 0);
      chk("rst_in_ready", in_ready, 1);

      run_one("pass", pk_in(5, -3, 127, -128), '0, 3'b000, 0, 1, 0, pk_out(5, -3, 127, -128), 0);
      run_one("relu", pk_in(-16, -1, 10, 100), '0, 3'b001, 6, 1, 0, pk_out(0, 0, 10, 100), 0);
      run_one("relu_clip", pk_in(-16, -1, 10, 100), '0, 3'b010, 6, 1, 0, pk_out(0, 0, 6, 6), 0);
      run_one("leaky", pk_in(-16, -1, 10, 100), '0, 3'b011, 6, 1, 0, pk_out(-2, -1, 10, 100), 0);
      run_one("act_other", pk_in(-16, -1, 10, 100), '0, 3'b110, 6, 1, 0, pk_out(-16, -1, 10, 100), 0);
      run_one("requant", pk_in(1000, -1000, 6, -6), pk_in(24, 0, 0, 0), 3'b000, 0, 3, 4,
              pk_out(127, -128, 1, -1), 2);
      run_one("round", pk_in(3, -3, 1, -1), '0, 3'b000, 0, 1, 1, pk_out(2, -1, 1, 0), 2);
      run_one("bias_sat", pk_in(32'h7fffffff, 32'h80000000, 0, 0), pk_in(1, -1, 0, 0), 3'b000, 0, 1, 24,
              pk_out(127, -128, 0, 0), 3);
      run_one("scale_max", pk_in(100, -1, 0, 2), '0, 3'b000, 0, 16'hffff, 16,
              pk_out(100, -1, 0, 2), 3);

      // Backpressure: 8 beats against out_ready pattern 1,0,0,1,0,1,1,0 repeating.
      bp_pat = 8'b01101001;
      for (int k = 0; k < 8; k++) bp_exp[k] = pk_out(k + 1, -(k + 1), 20 + k, 3 * k);
      act_type = 3'b000;
      scale    = 16'd1;
      shift    = 5'd0;
      in_bias  = '0;
      tx = 0;
      rx = 0;
      held_v = 1'b0;
      held_d = '0;
      for (int t = 0; t < 80 && rx < 8; t++) begin
         @(negedge clk);
         out_ready = bp_pat[t % 8];
         #1;
         chk("bp_in_ready", in_ready, !(out_valid && !out_ready));
         if (held_v) chk("bp_hold", out_data, held_d);
         held_v = out_valid && !out_ready;
         held_d = out_data;
         if (out_valid && out_ready) begin
            chk("bp_data", out_data, bp_exp[rx]);
            rx++;
         end
         in_valid = (tx < 8);
         in_data  = pk_in(tx + 1, -(tx + 1), 20 + tx, 3 * tx);
         if (in_valid && in_ready) tx++;
      end
      @(negedge clk);
      in_valid  = 1'b0;
      out_ready = 1'b1;
      chk("bp_count", rx, 8);
      repeat (4) begin
         @(negedge clk);
         chk("bp_nodup", out_valid, 0);
      end
      chk("bp_sat", sat_count, 3);

      // Reset with three saturating beats in flight.
      in_data  = pk_in(1000, -1000, 1000, -1000);
      in_valid = 1'b1;
      repeat (3) @(negedge clk);
      chk("rf_full", out_valid, 1);
      reset = 1'b1;
      @(negedge clk);
      chk("rf_out_valid", out_valid, 0);
      chk("rf_sat_count", sat_count, 0);
      reset    = 1'b0;
      in_valid = 1'b0;
      chk("rf_in_ready", in_ready, 1);
      repeat (6) begin
         @(negedge clk);
         chk("rf_no_stale", out_valid, 0);
      end

      // Saturation counter: 4 events per beat, sticks at all-ones.
      in_data  = pk_in(1000, -1000, 1000, -1000);
      in_valid = 1'b1;
      repeat (10) @(negedge clk);
      in_valid = 1'b0;
      repeat (6) @(negedge clk);
      chk("cnt_40", sat_count, 40);
      in_valid = 1'b1;
      repeat (16374) @(negedge clk);
      in_valid = 1'b0;
      repeat (6) @(negedge clk);
      chk("cnt_stick", sat_count, 16'hffff);
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (6) @(negedge clk);
      chk("cnt_stick2", sat_count, 16'hffff);

      // sat_clear coincident with a saturating accepted output beat.
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      wcnt = 0;
      while (!out_valid && wcnt < 10) begin
         @(negedge clk);
         wcnt++;
      end
      chk("clr_seen", out_valid, 1);
      sat_clear = 1'b1;
      @(negedge clk);
      sat_clear = 1'b0;
      chk("clr_coincident", sat_count, 0);
      @(negedge clk);
      chk("clr_after", sat_count, 0);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
